// File: rtl/lsp_pkg.sv
// Shared constants, FSM state type and window coefficient generator for the
// LSP autocorrelation stage.
package lsp_pkg;

    localparam int LSP_FRAME_LEN = 240;
    localparam int LSP_ORDER     = 10;
    localparam int LSP_ACC_WIDTH = 40;
    localparam int LSP_WIN_SPLIT = 200;

    localparam logic signed [31:0] LSP_Q15_ROUND = 32'sd16384;

    localparam longint TWO_PI_Q28 = 64'sd1686629713;
    localparam longint ONE_Q28    = 64'sd268435456;
    localparam longint HAM_A_Q28  = 64'sd144955146;
    localparam longint HAM_B_Q28  = 64'sd123480310;

    typedef enum logic {
        COLLECT = 1'b0,
        COMPUTE = 1'b1
    } acf_state_t;

    // G.729 hybrid window: Hamming half over 200 taps, quarter cosine over the last 40.
    function automatic logic signed [15:0] lsp_win_coef(input int n);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint w;
        if (n < LSP_WIN_SPLIT)
            x = (TWO_PI_Q28 * longint'(n)) / 64'sd399;
        else
            x = (TWO_PI_Q28 * longint'(n - LSP_WIN_SPLIT)) / 64'sd159;
        x2   = (x * x) >>> 28;
        term = ONE_Q28;
        sum  = ONE_Q28;
        for (int k = 0; k < 12; k++) begin
            term = -((term * x2) >>> 28) / longint'((2 * k + 1) * (2 * k + 2));
            sum  = sum + term;
        end
        if (n < LSP_WIN_SPLIT)
            w = HAM_A_Q28 - ((HAM_B_Q28 * sum) >>> 28);
        else
            w = sum;
        w = (w + 64'sd4096) >>> 13;
        if (w > 64'sd32767)
            w = 64'sd32767;
        if (w < 64'sd0)
            w = 64'sd0;
        return 16'(w);
    endfunction

endpackage

// File: rtl/lsp_acf_window_rom.sv
// Combinational 240x16 Q15 analysis window table, built at elaboration time.
module lsp_acf_window_rom
    import lsp_pkg::*;
(
    input  logic        [7:0]  addr,
    output logic signed [15:0] data
);

    logic signed [15:0] rom [LSP_FRAME_LEN];

    for (genvar i = 0; i < LSP_FRAME_LEN; i++) begin : g_coef
        localparam logic signed [15:0] COEF = lsp_win_coef(i);
        assign rom[i] = COEF;
    end

    assign data = (addr < 8'(LSP_FRAME_LEN)) ? rom[addr] : '0;

endmodule

// File: rtl/lsp_autocorr.sv
// Frame capture with optional Q15 windowing, then autocorrelation lags 0..10
// computed on a single pipelined MAC and streamed one lag per strobe.
module lsp_autocorr
    import lsp_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int ACC_WIDTH      = LSP_ACC_WIDTH
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        lsp_read_en,
    input  logic [RAM_DATA_WIDTH-1:0]   lsp_audio_sample,
    input  logic                        acf_win_en,
    output logic                        acf_valid,
    output logic [3:0]                  acf_lag,
    output logic signed [ACC_WIDTH-1:0] acf_data,
    output logic                        acf_done,
    output logic                        acf_busy,
    output logic                        acf_overrun
);

    acf_state_t state;
    acf_state_t state_next;

    logic        [7:0]           wr_ptr;
    logic        [3:0]           lag;
    logic        [7:0]           cyc;
    logic        [7:0]           issue_len;
    logic        [7:0]           rd_idx;
    logic                        capture;
    logic                        issuing;
    logic                        drain_end;
    logic                        strobe_cyc;
    logic                        rd_valid;
    logic                        prod_valid;
    logic signed [15:0]          sample_buf [LSP_FRAME_LEN];
    logic signed [15:0]          sample_in;
    logic signed [15:0]          win_coef;
    logic signed [15:0]          win_sample;
    logic signed [31:0]          win_prod;
    logic signed [31:0]          win_round;
    logic signed [15:0]          rd_a;
    logic signed [15:0]          rd_b;
    logic signed [31:0]          prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                        unused_sample_bits;

    assign unused_sample_bits = ^lsp_audio_sample[RAM_DATA_WIDTH-1:16];
    assign sample_in          = lsp_audio_sample[15:0];

    lsp_acf_window_rom u_win_rom (
        .addr (wr_ptr),
        .data (win_coef)
    );

    assign win_prod  = 32'(sample_in) * 32'(win_coef);
    assign win_round = (win_prod + LSP_Q15_ROUND) >>> 15;

    always_comb begin
        win_sample = sample_in;
        if (acf_win_en) begin
            if (win_round > 32'sd32767)
                win_sample = 16'sh7FFF;
            else if (win_round < -32'sd32768)
                win_sample = 16'sh8000;
            else
                win_sample = win_round[15:0];
        end
    end

    // Per-lag schedule: issue n=k..239 on cycles 0..239-k, two drain cycles, one strobe cycle.
    assign capture    = (state == COLLECT) && lsp_read_en;
    assign issue_len  = 8'(LSP_FRAME_LEN) - {4'd0, lag};
    assign issuing    = (state == COMPUTE) && (cyc < issue_len);
    assign drain_end  = (state == COMPUTE) && (cyc == issue_len + 8'd1);
    assign strobe_cyc = (state == COMPUTE) && (cyc == issue_len + 8'd2);
    assign rd_idx     = {4'd0, lag} + cyc;
    assign acc_sum    = acc + ACC_WIDTH'(prod);

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= COLLECT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (capture && wr_ptr == 8'(LSP_FRAME_LEN - 1)) state_next = COMPUTE;
            COMPUTE: if (strobe_cyc && lag == 4'(LSP_ORDER))         state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        acf_busy = (state == COMPUTE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && capture)
            sample_buf[wr_ptr] <= win_sample;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr      <= '0;
            lag         <= '0;
            cyc         <= '0;
            rd_valid    <= 1'b0;
            prod_valid  <= 1'b0;
            rd_a        <= '0;
            rd_b        <= '0;
            prod        <= '0;
            acc         <= '0;
            acf_valid   <= 1'b0;
            acf_done    <= 1'b0;
            acf_lag     <= '0;
            acf_data    <= '0;
            acf_overrun <= 1'b0;
        end else begin
            if (capture)
                wr_ptr <= (wr_ptr == 8'(LSP_FRAME_LEN - 1)) ? 8'd0 : wr_ptr + 8'd1;
            if (state == COMPUTE && lsp_read_en)
                acf_overrun <= 1'b1;

            if (strobe_cyc) begin
                cyc <= '0;
                lag <= (lag == 4'(LSP_ORDER)) ? 4'd0 : lag + 4'd1;
            end else if (state == COMPUTE) begin
                cyc <= cyc + 8'd1;
            end else begin
                cyc <= '0;
                lag <= '0;
            end

            rd_valid   <= issuing;
            prod_valid <= rd_valid;
            if (issuing) begin
                rd_a <= sample_buf[rd_idx];
                rd_b <= sample_buf[cyc];
            end
            prod <= 32'(rd_a) * 32'(rd_b);

            // Final product folds straight into the output register; acc restarts for the next lag.
            if (drain_end) begin
                acc      <= '0;
                acf_data <= acc_sum;
                acf_lag  <= lag;
            end else if (prod_valid) begin
                acc <= acc_sum;
            end
            acf_valid <= drain_end;
            acf_done  <= drain_end && (lag == 4'(LSP_ORDER));
        end
    end

endmodule

// File: doc/lsp_autocorr.md
# lsp_autocorr

Downstream consumer of the LSP coefficient stage's sample stream. Captures one 240-sample frame from `lsp_audio_sample` (qualified by `lsp_read_en`) and applies an optional Q15 analysis window. It then computes autocorrelation lags r[0..10] with a single multiply-accumulate (MAC) and streams them, one lag per strobe, to the Levinson-Durbin stage.

## Interface
- `RAM_DATA_WIDTH`, 32, width of incoming sample word; only bits [15:0] are used, as a signed Q15 value.
- `ACC_WIDTH`, 40, autocorrelation accumulator and output width.
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `lsp_read_en`  in  1  sample strobe; one sample per high cycle.
- `lsp_audio_sample`  in  RAM_DATA_WIDTH  sample word.
- `acf_win_en`  in  1  1: apply window ROM; 0: bypass (window = 1.0). Sampled per captured sample.
- `acf_valid`  out  1  one-cycle strobe, `acf_data` holds lag `acf_lag`.
- `acf_lag`  out  4  lag index 0..10.
- `acf_data`  out  ACC_WIDTH  signed r[acf_lag].
- `acf_done`  out  1  one-cycle pulse, coincident with the lag-10 strobe.
- `acf_busy`  out  1  high in COMPUTE.
- `acf_overrun`  out  1  sticky; set when a sample arrives outside COLLECT.

## Operation
- Reset: all outputs 0, state COLLECT, `wr_ptr`=0, `acf_overrun`=0. Buffer contents are don't-care.
- COLLECT:
  - Each `lsp_read_en` cycle computes `w = (s*win[wr_ptr] + 2^14) >>> 15`, saturated to [-32768, 32767]. With `acf_win_en`=0, `w = s`.
  - `w` is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - On the write with `wr_ptr`=239, `wr_ptr` wraps to 0 and the next state is COMPUTE.
- COMPUTE: for k = 0..10:
  - Clear the accumulator.
  - Issue n = k..239 at one per cycle, accumulating `acc += buf[n]*buf[n-k]` as a full 32-bit signed product.
  - After the pipeline drains, present `acc` on `acf_data` with `acf_valid`=1.
  - After k=10, return to COLLECT.
- Arithmetic: a 40-bit signed accumulator cannot overflow (240·2^30 < 2^39). No saturation and no normalisation; Levinson-Durbin normalises.
- Samples arriving in COMPUTE are dropped and set `acf_overrun`. The result in progress is unaffected. `acf_overrun` clears only on reset.
- `sys_rst` mid-frame or mid-compute: the frame is abandoned, no further strobes, and the block is back in COLLECT with `wr_ptr`=0 on the next cycle.
- `acf_data` and `acf_lag` hold their last value between strobes.

## Timing
- Capture: the buffer write lands 1 cycle after `lsp_read_en`. COMPUTE is entered on the cycle after the 240th strobe.
- MAC pipeline per lag: buffer read reg → product reg → accumulate, so 2 drain cycles after the last issue.
- Per lag k:
  - 240−k issue cycles, then 2 drain cycles, then a 1-cycle strobe: 243−k cycles total.
  - The next lag's issue starts the cycle after the strobe.
- With C = first COMPUTE cycle as 0:
  - lag-0 strobe at cycle 242.
  - lag-k strobe at Σ_{j<k}(243−j) + 242−k.
  - lag-10 strobe (with `acf_done`) at cycle 2617.
  - COLLECT resumes at cycle 2618.
- `acf_busy` is high for cycles 0..2617.
- Upstream frame period (≥80 samples/frame cadence) far exceeds 2618 cycles at `sys_clk`. Overrun signals a system misconfiguration.

## Structure
- Shared package `lsp_pkg`:
  - `LSP_FRAME_LEN`=240
  - `LSP_ORDER`=10
  - `LSP_ACC_WIDTH`=40
  - state enum {COLLECT, COMPUTE}
  - Q15 rounding constant
- Sub-module `lsp_acf_window_rom`: 240×16 synchronous-free combinational ROM, address = `wr_ptr`, data = G.729 hybrid window in Q15.
- Sample buffer: 240×16 register array with one write port and two combinational read ports (n and n−k). A dual-port RAM substitute is permitted only if the latency above is preserved.

## Test plan
- Window bypass, 240 samples all 1000 → r[k] = (240−k)·10^6: r0=240000000, r10=230000000. `acf_done` with lag 10 at cycle 2617 of COMPUTE.
- Bypass, impulse x[5]=32767, rest 0 → r0=1073676289, r1..r10=0.
- Bypass, all −32768 → r0=257698037760 (no overflow). Alternating +16384/−16384 → r[k] = (−1)^k·(240−k)·268435456, e.g. r1=−64156073984.
- 5 extra strobes during COMPUTE → `acf_overrun`=1 and stays 1. Results identical to the clean run. Next frame starts with `wr_ptr`=0.
- `sys_rst` asserted at COMPUTE cycle 1000 → no further `acf_valid`. All outputs 0 next cycle. A fresh frame then produces correct r[0..10].
- Window enabled, all 32767 → r[k] matches the bit-exact reference model using the ROM table and the rounding/saturation rule. Back-to-back frames yield two full strobe sequences.
